// File: rtl/ppi_bus_controller_if.sv
// Host-side bus bundle for the PPI bus controller.
// The master modport is the host or bench. The slave modport is the controller.
interface ppi_bus_controller_if;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic [1:0] A;
  logic [7:0] DataIn;
  logic [3:0] ControlEnable;
  logic [3:0] GroupControl;
  logic       BusDrive;
  logic [7:0] ControlWord;
  logic [7:0] PortCLatch;
  logic       ModeError;
  logic       BusError;

  modport master (
    output CS_n, RD_n, WR_n, A, DataIn,
    input  ControlEnable, GroupControl, BusDrive, ControlWord, PortCLatch,
           ModeError, BusError
  );

  modport slave (
    input  CS_n, RD_n, WR_n, A, DataIn,
    output ControlEnable, GroupControl, BusDrive, ControlWord, PortCLatch,
           ModeError, BusError
  );
endinterface

// File: rtl/ppi_bus_controller.sv
// Bus sequencer for the PPI8255A core.
// Synchronizes the host strobes and runs a small FSM that turns reads and
// writes into per-port enables. Holds the mode-0 control word and the
// port C output latch. Handles bit-set/reset writes to port C.
module ppi_bus_controller #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_CW    = 8'h9B
) (
  input logic                 Clk,
  input logic                 Reset,
  ppi_bus_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, COMMIT, ERROR} busState_t;

  // Direction decode: 1 means the port is an input.
  // Bit order is [0]=A, [1]=B, [2]=C-lower, [3]=C-upper.
  function automatic logic [3:0] decodeGroup(input logic [7:0] cw);
    return {cw[3], cw[0], cw[1], cw[4]};
  endfunction

  // Enables raised during a read of the given address. Address 11 yields no enable.
  function automatic logic [3:0] readEnable(input logic [1:0] addr);
    logic [3:0] en;
    en = 4'b0000;
    case (addr)
      2'b00:   en = 4'b0001;
      2'b01:   en = 4'b0010;
      2'b10:   en = 4'b1100;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  logic [2:0] syncChain [SYNC_STAGES];
  logic       sCS, sRD, sWR;

  busState_t  state;
  logic [7:0] controlWordReg;
  logic [7:0] portCLatchReg;
  logic [3:0] controlEnableReg;
  logic [3:0] groupControlReg;
  logic       busDriveReg;
  logic       modeErrorReg;
  logic       busErrorReg;

  // Strobe synchronizer. It idles high, so a reset looks like no strobe active.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) syncChain[i] <= 3'b111;
    end else begin
      syncChain[0] <= {bus.CS_n, bus.RD_n, bus.WR_n};
      for (int i = 1; i < SYNC_STAGES; i++) syncChain[i] <= syncChain[i-1];
    end
  end

  assign {sCS, sRD, sWR} = syncChain[SYNC_STAGES-1];

  // Bus FSM with registered outputs.
  // Outputs change on the same edge as the state transition, which gives
  // SYNC_STAGES+1 cycles of latency from a strobe edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state            <= IDLE;
      controlWordReg   <= RESET_CW;
      portCLatchReg    <= 8'h00;
      controlEnableReg <= 4'b0000;
      groupControlReg  <= decodeGroup(RESET_CW);
      busDriveReg      <= 1'b0;
      modeErrorReg     <= 1'b0;
      busErrorReg      <= 1'b0;
    end else begin
      // Direction follows the control word one cycle later.
      groupControlReg  <= decodeGroup(controlWordReg);
      controlEnableReg <= 4'b0000;
      busDriveReg      <= 1'b0;
      busErrorReg      <= 1'b0;

      case (state)
        IDLE: begin
          if (!sCS) begin
            if (!sRD && !sWR) begin
              state       <= ERROR;
              busErrorReg <= 1'b1;
            end else if (!sRD) begin
              state            <= READ;
              controlEnableReg <= readEnable(bus.A);
              busDriveReg      <= (bus.A != 2'b11);
            end else if (!sWR) begin
              state <= WRITE;
            end
          end
        end

        READ: begin
          if (sRD || sCS) begin
            state <= IDLE;
          end else begin
            controlEnableReg <= readEnable(bus.A);
            busDriveReg      <= (bus.A != 2'b11);
          end
        end

        WRITE: begin
          // The trailing edge of the write strobe wins over a simultaneous deselect.
          // Address and data are captured here, and the effects land as the FSM enters COMMIT.
          if (sWR) begin
            state <= COMMIT;
            case (bus.A)
              2'b00: if (!groupControlReg[0]) controlEnableReg[0] <= 1'b1;
              2'b01: if (!groupControlReg[1]) controlEnableReg[1] <= 1'b1;
              2'b10: begin
                if (!groupControlReg[2]) begin
                  portCLatchReg[3:0]  <= bus.DataIn[3:0];
                  controlEnableReg[2] <= 1'b1;
                end
                if (!groupControlReg[3]) begin
                  portCLatchReg[7:4]  <= bus.DataIn[7:4];
                  controlEnableReg[3] <= 1'b1;
                end
              end
              default: begin
                if (bus.DataIn[7]) begin
                  controlWordReg <= bus.DataIn;
                  portCLatchReg  <= 8'h00;
                  if ((bus.DataIn[6:5] != 2'b00) || bus.DataIn[2]) modeErrorReg <= 1'b1;
                end else begin
                  portCLatchReg[bus.DataIn[3:1]] <= bus.DataIn[0];
                  if (bus.DataIn[3]) controlEnableReg[3] <= 1'b1;
                  else               controlEnableReg[2] <= 1'b1;
                end
              end
            endcase
          end else if (sCS) begin
            state <= IDLE;
          end
        end

        COMMIT: state <= IDLE;

        ERROR: begin
          if (sRD && sWR) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ControlEnable = controlEnableReg;
  assign bus.GroupControl  = groupControlReg;
  assign bus.BusDrive      = busDriveReg;
  assign bus.ControlWord   = controlWordReg;
  assign bus.PortCLatch    = portCLatchReg;
  assign bus.ModeError     = modeErrorReg;
  assign bus.BusError      = busErrorReg;

endmodule

// File: tb/tb_ppi_bus_controller.sv
// Directed bench for ppi_bus_controller.
// A table of write transactions is applied first. Hand sequences then cover
// reads, strobe collisions and reset during a write.
module tb_ppi_bus_controller;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ppi_bus_controller_if bus();

  ppi_bus_controller #(.SYNC_STAGES(2), .RESET_CW(8'h9B)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net in case a sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic [7:0] expCw;
    logic [7:0] expLatch;
    logic [3:0] expGc;
    logic [3:0] expCe;
    int         expPulses;
    logic       expMe;
  } vecT;

  vecT vecs [15];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Full write strobe. Observes the enable pulses, their latency after the
  // WR_n rising edge, and any stray BusDrive or BusError.
  task automatic busWrite(input logic [1:0] addr, input logic [7:0] data,
                          output logic [3:0] ceOr, output int pulses,
                          output int firstK, output logic anyBad);
    ceOr = 4'b0000; pulses = 0; firstK = -1; anyBad = 1'b0;
    @(negedge clk);
    bus.A = addr; bus.DataIn = data; bus.CS_n = 1'b0; bus.WR_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      ceOr |= bus.ControlEnable;
      if (bus.ControlEnable != 4'b0000) pulses++;
      if (bus.BusDrive || bus.BusError) anyBad = 1'b1;
    end
    bus.WR_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      ceOr |= bus.ControlEnable;
      if (bus.ControlEnable != 4'b0000) begin
        pulses++;
        if (firstK < 0) firstK = k;
      end
      if (bus.BusDrive || bus.BusError) anyBad = 1'b1;
    end
    bus.CS_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Read strobe held for 7 observed cycles, then released.
  task automatic readCheck(input logic [1:0] addr, input logic [3:0] expCe, input logic expDrive);
    int holdOk;
    holdOk = 0;
    @(negedge clk);
    bus.A = addr; bus.CS_n = 1'b0; bus.RD_n = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 2) checkVal($sformatf("read%0d_pre", addr), {bus.BusDrive, bus.ControlEnable}, 5'b0);
      if (k >= 3 && {bus.BusDrive, bus.ControlEnable} == {expDrive, expCe}) holdOk++;
    end
    checkVal($sformatf("read%0d_hold", addr), holdOk, 7);
    bus.RD_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 2) checkVal($sformatf("read%0d_tail", addr), {bus.BusDrive, bus.ControlEnable}, {expDrive, expCe});
      if (k == 3) checkVal($sformatf("read%0d_drop", addr), {bus.BusDrive, bus.ControlEnable}, 5'b0);
    end
    bus.CS_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("read A=%0d enable=%b drive=%0d heldCycles=%0d", addr, expCe, expDrive, holdOk);
  endtask

  initial begin
    logic [3:0] ceOr;
    int         pulses, firstK, errPulses, errK;
    logic       anyBad, ceSeen;

    vecs[0]  = '{2'd3, 8'h80, 8'h80, 8'h00, 4'b0000, 4'b0000, 0, 1'b0};
    vecs[1]  = '{2'd2, 8'h55, 8'h80, 8'h55, 4'b0000, 4'b1100, 1, 1'b0};
    vecs[2]  = '{2'd3, 8'h07, 8'h80, 8'h5D, 4'b0000, 4'b0100, 1, 1'b0};
    vecs[3]  = '{2'd3, 8'h0F, 8'h80, 8'hDD, 4'b0000, 4'b1000, 1, 1'b0};
    vecs[4]  = '{2'd3, 8'h0E, 8'h80, 8'h5D, 4'b0000, 4'b1000, 1, 1'b0};
    vecs[5]  = '{2'd0, 8'h12, 8'h80, 8'h5D, 4'b0000, 4'b0001, 1, 1'b0};
    vecs[6]  = '{2'd1, 8'h34, 8'h80, 8'h5D, 4'b0000, 4'b0010, 1, 1'b0};
    vecs[7]  = '{2'd3, 8'h9B, 8'h9B, 8'h00, 4'b1111, 4'b0000, 0, 1'b0};
    vecs[8]  = '{2'd0, 8'hAA, 8'h9B, 8'h00, 4'b1111, 4'b0000, 0, 1'b0};
    vecs[9]  = '{2'd2, 8'hFF, 8'h9B, 8'h00, 4'b1111, 4'b0000, 0, 1'b0};
    vecs[10] = '{2'd3, 8'h01, 8'h9B, 8'h01, 4'b1111, 4'b0100, 1, 1'b0};
    vecs[11] = '{2'd3, 8'h81, 8'h81, 8'h00, 4'b0100, 4'b0000, 0, 1'b0};
    vecs[12] = '{2'd2, 8'hA5, 8'h81, 8'hA0, 4'b0100, 4'b1000, 1, 1'b0};
    vecs[13] = '{2'd3, 8'hC0, 8'hC0, 8'h00, 4'b0000, 4'b0000, 0, 1'b1};
    vecs[14] = '{2'd1, 8'h77, 8'hC0, 8'h00, 4'b0000, 4'b0010, 1, 1'b1};

    bus.CS_n = 1'b1; bus.RD_n = 1'b1; bus.WR_n = 1'b1; bus.A = 2'b00; bus.DataIn = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Outputs right after reset is released.
    checkVal("rst_cw", bus.ControlWord, 8'h9B);
    checkVal("rst_gc", bus.GroupControl, 4'b1111);
    checkVal("rst_ce", bus.ControlEnable, 4'b0000);
    checkVal("rst_latch", bus.PortCLatch, 8'h00);
    checkVal("rst_drive", bus.BusDrive, 1'b0);
    checkVal("rst_me", bus.ModeError, 1'b0);
    checkVal("rst_be", bus.BusError, 1'b0);
    $display("reset cw=%02h gc=%b", bus.ControlWord, bus.GroupControl);

    // Table-driven write transactions.
    for (int i = 0; i < 15; i++) begin
      busWrite(vecs[i].addr, vecs[i].data, ceOr, pulses, firstK, anyBad);
      $display("write[%0d] A=%0d D=%02h cw=%02h latch=%02h gc=%b ce=%b pulses=%0d lat=%0d me=%0d",
               i, vecs[i].addr, vecs[i].data, bus.ControlWord, bus.PortCLatch,
               bus.GroupControl, ceOr, pulses, firstK, bus.ModeError);
      checkVal($sformatf("w%0d_cw", i), bus.ControlWord, vecs[i].expCw);
      checkVal($sformatf("w%0d_latch", i), bus.PortCLatch, vecs[i].expLatch);
      checkVal($sformatf("w%0d_gc", i), bus.GroupControl, vecs[i].expGc);
      checkVal($sformatf("w%0d_ce", i), ceOr, vecs[i].expCe);
      checkVal($sformatf("w%0d_pulses", i), pulses, vecs[i].expPulses);
      checkVal($sformatf("w%0d_me", i), bus.ModeError, vecs[i].expMe);
      checkVal($sformatf("w%0d_bad", i), anyBad, 1'b0);
      if (vecs[i].expPulses > 0) checkVal($sformatf("w%0d_latency", i), firstK, 3);
    end

    // All ports become inputs again, then reads are performed.
    busWrite(2'd3, 8'h9B, ceOr, pulses, firstK, anyBad);
    $display("write A=3 D=9B cw=%02h gc=%b", bus.ControlWord, bus.GroupControl);
    checkVal("mode9b_gc", bus.GroupControl, 4'b1111);
    readCheck(2'd1, 4'b0010, 1'b1);
    readCheck(2'd2, 4'b1100, 1'b1);
    readCheck(2'd3, 4'b0000, 1'b0);

    // RD_n and WR_n low together produce a single-cycle BusError and no commit.
    errPulses = 0; errK = -1; ceSeen = 1'b0;
    @(negedge clk);
    bus.A = 2'd3; bus.DataIn = 8'h80; bus.CS_n = 1'b0; bus.RD_n = 1'b0; bus.WR_n = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.BusError) begin
        errPulses++;
        if (errK < 0) errK = k;
      end
      if (bus.ControlEnable != 4'b0000 || bus.BusDrive) ceSeen = 1'b1;
    end
    bus.RD_n = 1'b1; bus.WR_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.BusError) errPulses++;
      if (bus.ControlEnable != 4'b0000 || bus.BusDrive) ceSeen = 1'b1;
    end
    bus.CS_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("collision busErrorPulses=%0d at=%0d cw=%02h", errPulses, errK, bus.ControlWord);
    checkVal("coll_pulses", errPulses, 1);
    checkVal("coll_latency", errK, 3);
    checkVal("coll_cw", bus.ControlWord, 8'h9B);
    checkVal("coll_quiet", ceSeen, 1'b0);

    // Set up state that reset must visibly clear.
    busWrite(2'd3, 8'h80, ceOr, pulses, firstK, anyBad);
    busWrite(2'd3, 8'h0F, ceOr, pulses, firstK, anyBad);
    $display("pre-reset cw=%02h latch=%02h me=%0d", bus.ControlWord, bus.PortCLatch, bus.ModeError);
    checkVal("pre_rst_latch", bus.PortCLatch, 8'h80);
    checkVal("pre_rst_cw", bus.ControlWord, 8'h80);

    // Reset arrives while a control write is still in progress.
    @(negedge clk);
    bus.A = 2'd3; bus.DataIn = 8'h92; bus.CS_n = 1'b0; bus.WR_n = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkVal("arst_cw", bus.ControlWord, 8'h9B);
    checkVal("arst_latch", bus.PortCLatch, 8'h00);
    checkVal("arst_gc", bus.GroupControl, 4'b1111);
    checkVal("arst_me", bus.ModeError, 1'b0);
    checkVal("arst_ce", bus.ControlEnable, 4'b0000);
    checkVal("arst_drive", bus.BusDrive, 1'b0);
    bus.WR_n = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ceSeen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.ControlEnable != 4'b0000) ceSeen = 1'b1;
    end
    bus.CS_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset-in-write cw=%02h latch=%02h", bus.ControlWord, bus.PortCLatch);
    checkVal("abort_cw", bus.ControlWord, 8'h9B);
    checkVal("abort_latch", bus.PortCLatch, 8'h00);
    checkVal("abort_ce", ceSeen, 1'b0);

    // A mode write with D2 set is flagged even though D6:5 are 00.
    busWrite(2'd3, 8'h84, ceOr, pulses, firstK, anyBad);
    $display("write A=3 D=84 cw=%02h me=%0d", bus.ControlWord, bus.ModeError);
    checkVal("d2_me", bus.ModeError, 1'b1);
    checkVal("d2_cw", bus.ControlWord, 8'h84);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppi_bus_controller.md
Name: ppi_bus_controller

Overview:
- Control/sequencing block for the PPI8255A core: turns the host bus strobes (CS_n, RD_n, WR_n, A[1:0]) into per-port ControlEnable/GroupControl signals for the three EightBitPort instances (A, B, C-upper/C-lower).
- Holds the mode-0 control word and the port C output latch, and performs Bit-Set/Reset (BSR) writes.
- Sits between the external bus pins and the EightBitPort datapath.

Parameters:
- SYNC_STAGES, 2, synchronizer depth applied to CS_n/RD_n/WR_n (legal values: 2 or 3).
- RESET_CW, 8'h9B, control word loaded at reset (mode 0, every port configured as input).

Ports:
- Clk  input  1  system clock; every register is rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- CS_n  input  1  chip select, active low.
- RD_n  input  1  read strobe, active low.
- WR_n  input  1  write strobe, active low.
- A  input  2  register address: 00=A, 01=B, 10=C, 11=control.
- DataIn  input  8  write data from the host bus.
- ControlEnable  output  4  per-port transfer enable [0]=A, [1]=B, [2]=C-lower, [3]=C-upper.
- GroupControl  output  4  per-port direction, same bit order; 1 = port is input (port drives DataBus), 0 = output.
- BusDrive  output  1  DataBus output enable toward the host; high only during a legal read.
- ControlWord  output  8  current control word.
- PortCLatch  output  8  port C output latch (written by data writes and BSR).
- ModeError  output  1  sticky; set by an unsupported mode request, cleared by reset only.
- BusError  output  1  one-cycle pulse on RD_n and WR_n both low while selected.

Behaviour:
- Reset (async): ControlWord=RESET_CW, PortCLatch=0, ControlEnable=0, GroupControl decoded from RESET_CW (=4'b1111), BusDrive=0, ModeError=0, BusError=0, FSM=IDLE. Reset mid-transfer aborts the transfer and no commit occurs.
- Strobes pass through SYNC_STAGES flops. sRD, sWR and sCS are the synchronized versions. A and DataIn are sampled in the commit cycle and must be stable for the whole strobe.
- GroupControl decode, registered from ControlWord: [0]=D4, [1]=D1, [2]=D0, [3]=D3.
- FSM states: IDLE, READ, WRITE, COMMIT, ERROR.
- IDLE -> READ when sCS=0, sRD=0, sWR=1.
- IDLE -> WRITE when sCS=0, sWR=0, sRD=1.
- IDLE -> ERROR when sCS=0 and sRD=0 and sWR=0. BusError pulses for one cycle. ERROR returns to IDLE once sRD=1 and sWR=1.
- READ with A in 00/01/10:
  - BusDrive=1 and ControlEnable[addressed]=1 every cycle in READ.
  - For A=10, both bits [2] and [3] are asserted.
  - Exit to IDLE when sRD=1 or sCS=1. Both outputs drop in that same cycle.
- READ with A=11: illegal. BusDrive=0, no enable, state is held until RD releases.
- WRITE: no outputs. Waits for sWR=1 (trailing edge), then goes to COMMIT for exactly one cycle, then IDLE. If sCS rises before sWR, go to IDLE with no commit.
- COMMIT, A=00/01: ControlEnable[addressed] pulses for 1 cycle, but only if that port's GroupControl=0. A write to an input port is silently dropped.
- COMMIT, A=10: PortCLatch nibbles are updated only for halves configured as output. The matching enable bit(s) pulse.
- COMMIT, A=11, DataIn[7]=1 (mode set):
  - ControlWord takes DataIn and PortCLatch is cleared.
  - If DataIn[6:5]!=00 or DataIn[2]!=0, ModeError is set. The direction bits are still applied and the mode bits are stored as written.
  - New GroupControl is visible in the cycle after COMMIT.
- COMMIT, A=11, DataIn[7]=0 (BSR): PortCLatch[DataIn[3:1]] = DataIn[0]. ControlWord is unchanged. ControlEnable[2] or [3] pulses according to which half the bit falls in, regardless of direction.
- Latency: write takes effect SYNC_STAGES+1 cycles after the WR_n rising edge. Read enables assert SYNC_STAGES+1 cycles after the RD_n falling edge.
- A new strobe is recognised only from IDLE. Back-to-back strobes need >=1 IDLE cycle.

Test Plan:
- Reset release -> ControlWord=8'h9B, GroupControl=4'b1111, all enables 0, PortCLatch=0, BusDrive=0.
- Write 8'h80 to A=11 -> ControlWord=8'h80, GroupControl=4'b0000, ModeError=0. Then write 8'h55 to A=10 -> PortCLatch=8'h55 and ControlEnable=4'b1100 for exactly one cycle.
- With CW=8'h80, BSR writes 8'h07 then 8'h0E -> PortCLatch bit3=1 then bit7=0. ControlWord stays 8'h80. One-cycle pulses on ControlEnable[2], then ControlEnable[3].
- With CW=8'h9B, read A=01 for 6 cycles -> BusDrive=1 and ControlEnable=4'b0010 held until RD_n rises. A write to A=00 in the same mode produces no enable.
- Mode write 8'hC0 -> ModeError=1 and stays 1 through later legal writes. RD_n and WR_n low together -> single-cycle BusError, no commit.
- Assert Reset while in WRITE (WR_n still low) -> no commit occurs, and all outputs return to reset values asynchronously.
